pd_freq_sweep_ctrl: RTL and testbench

//  Sequencer for the PhaseDetector LO: steps the phase increment across a frequency window and

---
 rtl/pd_freq_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_pd_freq_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_freq_sweep_ctrl.sv
// rtl/pd_freq_sweep_ctrl.sv - PhaseDetector LO sweep sequencer: steps pinc, scores |I|+|Q|, parks on best step.
// Optional per-step trace outputs are built when PD_SWEEP_TRACE_EN is defined.
module pd_freq_sweep_ctrl #(
  parameter int AVG_LOG2   = 4,
  parameter int RST_CYCLES = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        abort_in,
  input  logic [31:0] f_start_in,
  input  logic [31:0] f_step_in,
  input  logic [15:0] n_steps_in,
  input  logic [23:0] settle_in,
  input  logic [31:0] I_in,
  input  logic [31:0] Q_in,
  output logic [31:0] pinc_out,
  output logic        pd_on_out,
  output logic        pd_rst_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        locked_out,
  output logic [31:0] best_pinc_out,
  output logic [32:0] best_mag_out
`ifdef PD_SWEEP_TRACE_EN
  ,
  output logic        trace_valid_out,
  output logic [15:0] trace_idx_out,
  output logic [32:0] trace_mag_out
`endif
);

  localparam int          ACC_W    = 33 + AVG_LOG2;
  localparam logic [23:0] RST_LAST = 24'(RST_CYCLES - 1);
  localparam logic [23:0] ACC_LAST = 24'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_SETTLE, S_ACCUM, S_COMPARE, S_FINAL, S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        cnt_q, cnt_d;
  logic [15:0]        idx_q, idx_d;
  logic [15:0]        last_idx_q, last_idx_d;
  logic [31:0]        f_step_q, f_step_d;
  logic [23:0]        settle_q, settle_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [31:0]        pinc_q, pinc_d;
  logic [31:0]        best_pinc_q, best_pinc_d;
  logic [32:0]        best_mag_q, best_mag_d;
  logic               pd_on_q, pd_on_d;
  logic               pd_rst_q, pd_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               locked_q, locked_d;
`ifdef PD_SWEEP_TRACE_EN
  logic               trace_valid_q, trace_valid_d;
  logic [15:0]        trace_idx_q, trace_idx_d;
  logic [32:0]        trace_mag_q, trace_mag_d;
`endif

  // Magnitudes are formed in 33 bits so |-2^31| = 2^31 cannot overflow.
  logic [32:0] abs_i, abs_q, sample_mag, avg;
  assign abs_i      = I_in[31] ? (33'd0 - {1'b1, I_in}) : {1'b0, I_in};
  assign abs_q      = Q_in[31] ? (33'd0 - {1'b1, Q_in}) : {1'b0, Q_in};
  assign sample_mag = abs_i + abs_q;
  assign avg        = acc_q[AVG_LOG2 +: 33];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    f_step_d    = f_step_q;
    settle_d    = settle_q;
    acc_d       = acc_q;
    pinc_d      = pinc_q;
    best_pinc_d = best_pinc_q;
    best_mag_d  = best_mag_q;
    done_d      = 1'b0;
`ifdef PD_SWEEP_TRACE_EN
    trace_valid_d = 1'b0;
    trace_idx_d   = trace_idx_q;
    trace_mag_d   = trace_mag_q;
`endif
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (start_in && !abort_in) begin
          state_d     = S_RESET;
          cnt_d       = 24'd0;
          idx_d       = 16'd0;
          last_idx_d  = (n_steps_in == 16'd0) ? 16'd0 : n_steps_in - 16'd1;
          f_step_d    = f_step_in;
          settle_d    = settle_in;
          acc_d       = '0;
          pinc_d      = f_start_in;
          best_pinc_d = f_start_in;
          best_mag_d  = 33'd0;
        end
      end
      S_RESET: begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == RST_LAST) begin
          state_d = (settle_q == 24'd0) ? S_ACCUM : S_SETTLE;
          cnt_d   = 24'd0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == settle_q - 24'd1) begin
          state_d = S_ACCUM;
          cnt_d   = 24'd0;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + ACC_W'(sample_mag);
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == ACC_LAST) begin
          state_d = S_COMPARE;
          cnt_d   = 24'd0;
        end
      end
      S_COMPARE: begin
        // Strict compare so a tie keeps the earlier step.
        if (avg > best_mag_q) begin
          best_mag_d  = avg;
          best_pinc_d = pinc_q;
        end
        acc_d = '0;
`ifdef PD_SWEEP_TRACE_EN
        trace_valid_d = 1'b1;
        trace_idx_d   = idx_q;
        trace_mag_d   = avg;
`endif
        if (idx_q == last_idx_q) begin
          state_d = S_FINAL;
          pinc_d  = best_pinc_d;
        end else begin
          idx_d   = idx_q + 16'd1;
          pinc_d  = pinc_q + f_step_q;
          state_d = (settle_q == 24'd0) ? S_ACCUM : S_SETTLE;
        end
      end
      S_FINAL: begin
        cnt_d = cnt_q + 24'd1;
        if (cnt_q == settle_q) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_in && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      pinc_d      = pinc_q;
      best_pinc_d = best_pinc_q;
      best_mag_d  = best_mag_q;
      done_d      = 1'b0;
`ifdef PD_SWEEP_TRACE_EN
      trace_valid_d = 1'b0;
      trace_idx_d   = trace_idx_q;
      trace_mag_d   = trace_mag_q;
`endif
    end

    pd_rst_d = (state_d == S_RESET);
    pd_on_d  = (state_d != S_IDLE);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HOLD);
    locked_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= 24'd0;
      idx_q       <= 16'd0;
      last_idx_q  <= 16'd0;
      f_step_q    <= 32'd0;
      settle_q    <= 24'd0;
      acc_q       <= '0;
      pinc_q      <= 32'd0;
      best_pinc_q <= 32'd0;
      best_mag_q  <= 33'd0;
      pd_on_q     <= 1'b0;
      pd_rst_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
`ifdef PD_SWEEP_TRACE_EN
      trace_valid_q <= 1'b0;
      trace_idx_q   <= 16'd0;
      trace_mag_q   <= 33'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      f_step_q    <= f_step_d;
      settle_q    <= settle_d;
      acc_q       <= acc_d;
      pinc_q      <= pinc_d;
      best_pinc_q <= best_pinc_d;
      best_mag_q  <= best_mag_d;
      pd_on_q     <= pd_on_d;
      pd_rst_q    <= pd_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      locked_q    <= locked_d;
`ifdef PD_SWEEP_TRACE_EN
      trace_valid_q <= trace_valid_d;
      trace_idx_q   <= trace_idx_d;
      trace_mag_q   <= trace_mag_d;
`endif
    end
  end

  assign pinc_out      = pinc_q;
  assign pd_on_out     = pd_on_q;
  assign pd_rst_out    = pd_rst_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign locked_out    = locked_q;
  assign best_pinc_out = best_pinc_q;
  assign best_mag_out  = best_mag_q;
`ifdef PD_SWEEP_TRACE_EN
  assign trace_valid_out = trace_valid_q;
  assign trace_idx_out   = trace_idx_q;
  assign trace_mag_out   = trace_mag_q;
`endif

endmodule

// File: tb/tb_pd_freq_sweep_ctrl.sv
// tb/tb_pd_freq_sweep_ctrl.sv - randomized directed bench for pd_freq_sweep_ctrl against a timing/score reference model.
module tb_pd_freq_sweep_ctrl;
  localparam int R   = 8;
  localparam int AVG = 16;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic        abort_in = 1'b0;
  logic [31:0] f_start_in = '0;
  logic [31:0] f_step_in = '0;
  logic [15:0] n_steps_in = '0;
  logic [23:0] settle_in = '0;
  logic [31:0] I_in = '0;
  logic [31:0] Q_in = '0;
  logic [31:0] pinc_out;
  logic        pd_on_out, pd_rst_out, busy_out, done_out, locked_out;
  logic [31:0] best_pinc_out;
  logic [32:0] best_mag_out;
`ifdef PD_SWEEP_TRACE_EN
  logic        trace_valid_out;
  logic [15:0] trace_idx_out;
  logic [32:0] trace_mag_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] si [0:511];
  logic [31:0] sq [0:511];
  longint      mags [0:63];
  logic [31:0] last_best_pinc;

  always #5 clk_in = ~clk_in;

  pd_freq_sweep_ctrl #(.AVG_LOG2(4), .RST_CYCLES(R)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .abort_in(abort_in),
    .f_start_in(f_start_in), .f_step_in(f_step_in), .n_steps_in(n_steps_in), .settle_in(settle_in),
    .I_in(I_in), .Q_in(Q_in), .pinc_out(pinc_out), .pd_on_out(pd_on_out), .pd_rst_out(pd_rst_out),
    .busy_out(busy_out), .done_out(done_out), .locked_out(locked_out),
    .best_pinc_out(best_pinc_out), .best_mag_out(best_mag_out)
`ifdef PD_SWEEP_TRACE_EN
    , .trace_valid_out(trace_valid_out), .trace_idx_out(trace_idx_out), .trace_mag_out(trace_mag_out)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint absv(input logic [31:0] v);
    longint a;
    a = longint'($signed(v));
    return (a < 0) ? -a : a;
  endfunction

  function automatic logic [31:0] rnd_signed(input int unsigned lo, input int unsigned hi);
    logic [31:0] v;
    v = $urandom_range(hi, lo);
    if ($urandom_range(1, 0) == 1) v = -v;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pinc"}, pinc_out, 0);
    chk({tag, "_best_pinc"}, best_pinc_out, 0);
    chk({tag, "_best_mag"}, best_mag_out, 0);
    chk({tag, "_flags"}, {busy_out, done_out, locked_out, pd_on_out, pd_rst_out}, 0);
  endtask

  // mode 0: random with a dominant step `peak`; mode 1: equal |I|+|Q| every sample; mode 2: all -2^31
  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fst, input int n, input int s,
                           input int mode, input int peak, input int abort_t, input int reset_t);
    int neff, d, dur, best_idx, done_at, ndone, rst_hi, jc, ntr, ts;
    longint sum, best_m;
    logic [31:0] c1, c2, exp_pinc;
    logic bad;
    neff = (n == 0) ? 1 : n;
    d    = s + AVG + 1;
    dur  = R + neff * d + s + 1;
    c1   = $urandom_range(1 << 28, 0);
    c2   = $urandom_range(1 << 28, 0);
    for (int t = 0; t < 512; t++) begin
      case (mode)
        1: begin
          si[t] = ($urandom_range(1, 0) == 1) ? c1 : -c1;
          sq[t] = ($urandom_range(1, 0) == 1) ? c2 : -c2;
        end
        2: begin
          si[t] = 32'h8000_0000;
          sq[t] = 32'h8000_0000;
        end
        default: begin
          si[t] = rnd_signed(0, 1 << 20);
          sq[t] = rnd_signed(0, 1 << 20);
        end
      endcase
    end
    if (mode == 0) begin
      for (int k = 0; k < AVG; k++) begin
        ts = R + peak * d + s + 1 + k;
        si[ts] = rnd_signed(1 << 29, 1 << 30);
        sq[ts] = rnd_signed(1 << 29, 1 << 30);
      end
    end
    best_m = 0;
    best_idx = 0;
    for (int j = 0; j < neff; j++) begin
      sum = 0;
      for (int k = 0; k < AVG; k++) begin
        ts = R + j * d + s + 1 + k;
        sum += absv(si[ts]) + absv(sq[ts]);
      end
      mags[j] = sum / AVG;
      if (mags[j] > best_m) begin
        best_m = mags[j];
        best_idx = j;
      end
    end

    @(negedge clk_in);
    f_start_in = fs; f_step_in = fst; n_steps_in = 16'(n); settle_in = 24'(s);
    start_in = 1'b1; I_in = si[0]; Q_in = sq[0];
    @(posedge clk_in); #1;
    start_in = 1'b0;
    f_start_in = $urandom; f_step_in = $urandom; n_steps_in = 16'($urandom); settle_in = 24'($urandom);
    chk("start_busy", busy_out, 1);
    chk("start_pinc", pinc_out, fs);
    chk("start_locked", locked_out, 0);
    rst_hi = int'(pd_rst_out);
    ndone = 0; done_at = -1; ntr = 0; bad = 1'b0;
    for (int t = 1; t <= dur + 3; t++) begin
      @(negedge clk_in);
      I_in = si[t]; Q_in = sq[t];
      if (t == abort_t) abort_in = 1'b1;
      if (t == reset_t) rst_n_in = 1'b0;
      if (t == dur / 2 && abort_t < 0 && reset_t < 0) start_in = 1'b1;
      @(posedge clk_in); #1;
      abort_in = 1'b0; start_in = 1'b0;
      if (t == abort_t) begin
        jc = ((t - 1) < R) ? 0 : (t - 1 - R) / d;
        if (jc > neff - 1) jc = neff - 1;
        exp_pinc = fs + fst * jc;
        chk("abort_busy", busy_out, 0);
        chk("abort_pd_on", pd_on_out, 0);
        chk("abort_pd_rst", pd_rst_out, 0);
        chk("abort_locked", locked_out, 0);
        chk("abort_pinc", pinc_out, exp_pinc);
        for (int k = 0; k < 6; k++) begin
          @(posedge clk_in); #1;
          if (done_out || busy_out) bad = 1'b1;
        end
        chk("abort_quiet", bad, 0);
        return;
      end
      if (t == reset_t) begin
        chk_all_zero("midreset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        return;
      end
      rst_hi += int'(pd_rst_out);
      if (done_out) begin
        ndone++;
        done_at = t;
      end
      for (int j = 0; j < neff; j++) begin
        if (t == R + j * d + s + 1) begin
          exp_pinc = fs + fst * j;
          chk("step_pinc", pinc_out, exp_pinc);
        end
      end
`ifdef PD_SWEEP_TRACE_EN
      if (trace_valid_out) begin
        chk("trace_idx", trace_idx_out, ntr);
        chk("trace_mag", trace_mag_out, mags[ntr]);
        ntr++;
      end
`endif
    end
    exp_pinc = fs + fst * best_idx;
    chk("done_cycle", done_at, dur);
    chk("done_count", ndone, 1);
    chk("pd_rst_len", rst_hi, R);
    chk("hold_locked", locked_out, 1);
    chk("hold_busy", busy_out, 0);
    chk("hold_pd_on", pd_on_out, 1);
    chk("best_pinc", best_pinc_out, exp_pinc);
    chk("best_mag", best_mag_out, best_m);
    chk("park_pinc", pinc_out, exp_pinc);
`ifdef PD_SWEEP_TRACE_EN
    chk("trace_count", ntr, neff);
`endif
    last_best_pinc = exp_pinc;
  endtask

  initial begin
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_all_zero("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("idle_busy", busy_out, 0);

    run_sweep(32'h0100_0000, 32'h0010_0000, 4, 10, 0, 2, -1, -1);
    run_sweep($urandom, $urandom, 5, 3, 1, 0, -1, -1);
    run_sweep($urandom, $urandom, 0, 0, 0, 0, -1, -1);
    run_sweep(32'hFFF0_0000, 32'h0010_0000, 3, 2, 0, $urandom_range(2, 0), -1, -1);
    run_sweep($urandom, $urandom, 2, 1, 2, 0, -1, -1);
    chk("bigmag_const", best_mag_out, 64'h1_0000_0000);

    for (int r = 0; r < 3; r++) begin
      int n_r;
      n_r = $urandom_range(6, 1);
      run_sweep($urandom, $urandom, n_r, $urandom_range(12, 0), 0, $urandom_range(n_r - 1, 0), -1, -1);
    end

    @(negedge clk_in);
    start_in = 1'b1; abort_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0; abort_in = 1'b0;
    chk("startabort_busy", busy_out, 0);
    chk("startabort_locked", locked_out, 0);
    chk("startabort_pd_on", pd_on_out, 0);
    chk("startabort_pinc", pinc_out, last_best_pinc);
    repeat (3) @(posedge clk_in);
    #1;
    chk("startabort_stay", {busy_out, done_out}, 0);

    run_sweep(32'h0100_0000, 32'h0010_0000, 4, 10, 0, 1, R + 27 + 3, -1);
    run_sweep($urandom, $urandom, 3, 4, 0, 0, -1, R + 4 + 1 + 5);
    run_sweep(32'h0200_0000, 32'h0001_0000, 2, 0, 0, 1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
